// File: rtl/chan_scan_sel.sv
// chan_scan_sel: eight-channel sample selector with manual and scan modes.
//   In MANUAL, the channel that sel names is registered onto dout every cycle.
//   In SCAN, an internal pointer steps through channels 0..7. Each channel is
//   held for dwell+1 cycles, and wrap pulses when the pointer rolls over 7->0.
// Ports:
//   clk   - clock; all state changes on its rising edge
//   rst   - synchronous active-high reset
//   din   - eight packed channels; channel k is din[k*W +: W]
//   sel   - manual channel index
//   mode  - 0 = manual, 1 = scan; sampled only on an accepted start
//   dwell - cycles per channel minus one; latched on an accepted start
//   start - request to leave IDLE (ignored outside IDLE)
//   stop  - request to return to IDLE (wins over start)
//   dout  - registered selected channel data
//   ch    - index of the channel currently on dout
//   valid - dout carries a sample taken in MANUAL or SCAN
//   wrap  - one-cycle pulse when ch changes from 7 to 0 in SCAN
module chan_scan_sel #(
  parameter int W       = 3,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*W-1:0]     din,
  input  logic [2:0]         sel,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               start,
  input  logic               stop,
  output logic [W-1:0]       dout,
  output logic [2:0]         ch,
  output logic               valid,
  output logic               wrap
);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t             state;
  logic [2:0]         ptr;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_q;
  logic [W-1:0]       chan [8];

  always_comb begin
    for (int unsigned k = 0; k < 8; k++) begin
      chan[k] = din[k*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      dout    <= '0;
      ch      <= '0;
      valid   <= 1'b0;
      wrap    <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
      dwell_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          wrap  <= 1'b0;
          if (start && !stop) begin
            state   <= mode ? SCAN : MANUAL;
            dwell_q <= dwell;
            ptr     <= '0;
            cnt     <= '0;
          end
        end
        MANUAL: begin
          wrap <= 1'b0;
          if (stop) begin
            state <= IDLE;
            valid <= 1'b0;
          end else begin
            dout  <= chan[sel];
            ch    <= sel;
            valid <= 1'b1;
          end
        end
        SCAN: begin
          if (stop) begin
            state <= IDLE;
            valid <= 1'b0;
            wrap  <= 1'b0;
          end else begin
            dout  <= chan[ptr];
            ch    <= ptr;
            valid <= 1'b1;
            // valid gates out the first SCAN sample. On that cycle ch may still
            // hold 7 from an earlier run, and a 7->0 change then is not a wrap.
            wrap  <= valid && (ch == 3'd7) && (ptr == 3'd0);
            if (cnt == dwell_q) begin
              ptr <= ptr + 3'd1;
              cnt <= '0;
            end else begin
              cnt <= cnt + DWELL_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chan_scan_sel.sv
module tb_chan_scan_sel;

  localparam int W       = 3;
  localparam int DWELL_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [8*W-1:0]     din;
  logic [2:0]         sel;
  logic               mode;
  logic [DWELL_W-1:0] dwell;
  logic               start;
  logic               stop;
  logic [W-1:0]       dout;
  logic [2:0]         ch;
  logic               valid;
  logic               wrap;

  chan_scan_sel #(.W(W), .DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .sel   (sel),
    .mode  (mode),
    .dwell (dwell),
    .start (start),
    .stop  (stop),
    .dout  (dout),
    .ch    (ch),
    .valid (valid),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       v;
    logic [2:0] d;
    logic [2:0] c;
    logic       w;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Each expectation describes the outputs after the next rising edge.
  task automatic drive(input string nm, input logic r, input logic st, input logic sp,
                       input logic md, input logic [2:0] s, input logic [3:0] dw,
                       input logic ev, input logic [2:0] ed, input logic [2:0] ec,
                       input logic ew);
    exp_t e;
    @(negedge clk);
    rst   = r;
    start = st;
    stop  = sp;
    mode  = md;
    sel   = s;
    dwell = dw;
    e.name = nm;
    e.v = ev;
    e.d = ed;
    e.c = ec;
    e.w = ew;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per edge and compares it with the DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (valid !== e.v || dout !== e.d || ch !== e.c || wrap !== e.w) begin
          errors++;
          $display("FAIL %s: got valid=%b dout=%0d ch=%0d wrap=%b, want valid=%b dout=%0d ch=%0d wrap=%b",
                   e.name, valid, dout, ch, wrap, e.v, e.d, e.c, e.w);
        end
      end
    end
  end

  initial begin
    logic [2:0] ex;
    for (int k = 0; k < 8; k++) din[k*W +: W] = 3'(k);
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; sel = 3'd0; dwell = 4'd0;

    // Reset state and idle hold
    drive("reset0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("reset1", 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    drive("idle_after_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Manual select
    drive("manual_start", 0, 1, 0, 0, 5, 0, 0, 0, 0, 0);
    drive("manual_sel5", 0, 0, 0, 0, 5, 0, 1, 5, 5, 0);
    drive("manual_sel2", 0, 0, 0, 0, 2, 0, 1, 2, 2, 0);
    drive("manual_start_ignored", 0, 1, 0, 1, 7, 0, 1, 7, 7, 0);
    drive("manual_stop", 0, 0, 1, 0, 3, 0, 0, 7, 7, 0);
    drive("idle_hold", 0, 0, 0, 0, 3, 0, 0, 7, 7, 0);

    // Scan with dwell=0, entered while ch still holds 7 from manual
    drive("scan0_start", 0, 1, 0, 1, 0, 0, 0, 7, 7, 0);
    for (int i = 0; i < 10; i++) begin
      ex = 3'(i % 8);
      // mode/dwell changes mid-scan must be ignored
      drive("scan0_seq", 0, 0, 0, 0, 3, 4'd5, 1, ex, ex, (i == 8));
    end
    drive("scan0_stop", 0, 0, 1, 1, 0, 0, 0, 1, 1, 0);

    // Scan with dwell=2: wrap 24 cycles after the first sample, then stop at ch 4
    drive("scan2_start", 0, 1, 0, 1, 0, 4'd2, 0, 1, 1, 0);
    for (int i = 0; i < 38; i++) begin
      ex = 3'((i / 3) % 8);
      drive("scan2_seq", 0, 0, 0, 1, 0, 4'd0, 1, ex, ex, (i == 24));
    end
    drive("scan2_stop_hold", 0, 0, 1, 1, 0, 0, 0, 4, 4, 0);
    drive("idle_hold4", 0, 0, 0, 1, 0, 0, 0, 4, 4, 0);
    drive("restart_scan", 0, 1, 0, 1, 0, 0, 0, 4, 4, 0);
    drive("restart_ch0", 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    drive("restart_ch1", 0, 0, 0, 1, 0, 0, 1, 1, 1, 0);

    // start and stop together: stop wins in SCAN and in IDLE
    drive("both_in_scan", 0, 1, 1, 1, 0, 0, 0, 1, 1, 0);
    drive("both_in_idle", 0, 1, 1, 1, 0, 0, 0, 1, 1, 0);
    drive("still_idle", 0, 0, 0, 1, 0, 0, 0, 1, 1, 0);

    // Reset mid-dwell overrides start
    drive("scan3_start", 0, 1, 0, 1, 0, 4'd3, 0, 1, 1, 0);
    drive("scan3_s0", 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    drive("scan3_s1", 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    drive("scan3_s2", 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    drive("rst_mid_dwell", 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    drive("idle_after_rst", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // Maximum dwell: 16 cycles per channel
    drive("scanF_start", 0, 1, 0, 1, 0, 4'hF, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) begin
      ex = (i < 16) ? 3'd0 : 3'd1;
      drive("scanF_seq", 0, 0, 0, 1, 0, 0, 1, ex, ex, 0);
    end

    // Drain the scoreboard, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
